// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_t;

  // Hex code of each key, indexed [row][col].
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } low_idx_t;

  // Index of the single low row; valid is clear for idle or multi-key patterns.
  function automatic low_idx_t one_hot_low_idx(input logic [NUM_ROWS-1:0] rows);
    low_idx_t res;
    res.valid = 1'b1;
    res.idx   = 2'd0;
    case (rows)
      4'b1110: res.idx = 2'd0;
      4'b1101: res.idx = 2'd1;
      4'b1011: res.idx = 2'd2;
      4'b0111: res.idx = 2'd3;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; reset value matches the idle level of the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press and release debounce.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_tick,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  logic [3:0] rows_s;
  kp_state_t  state_q;
  logic [3:0] cnt_q;
  logic [1:0] row_q;
  logic [1:0] col_q;
  low_idx_t   hit;
  logic       idle;
  logic [3:0] cnt_inc;
  logic       cnt_done;

  sync_2ff #(
    .WIDTH    (NUM_ROWS),
    .RESET_VAL(4'hF)
  ) u_row_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (row_in),
    .q    (rows_s)
  );

  assign hit      = one_hot_low_idx(rows_s);
  assign idle     = (rows_s == 4'hF);
  assign cnt_inc  = cnt_q + 4'd1;
  assign cnt_done = (cnt_inc == 4'(DEBOUNCE_TICKS));

  // Scan/debounce FSM; all state and outputs advance only on scan ticks.
  // col_q is the column index, col_out its registered active-low decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      cnt_q     <= 4'd0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      col_out   <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_tick) begin
        unique case (state_q)
          SCAN: begin
            if (hit.valid) begin
              row_q   <= hit.idx;
              cnt_q   <= 4'd1;
              state_q <= DEBOUNCE;
            end else begin
              col_q   <= col_q + 2'd1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
          DEBOUNCE: begin
            if (hit.valid && hit.idx == row_q) begin
              cnt_q <= cnt_inc;
              if (cnt_done) begin
                key_code  <= KEY_MAP[row_q][col_q];
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state_q   <= HELD;
              end
            end else begin
              state_q <= SCAN;
              col_q   <= col_q + 2'd1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
          HELD: begin
            // Extra keys while held are ignored; only all-idle starts release.
            if (idle) begin
              cnt_q   <= 4'd1;
              state_q <= RELEASE;
            end
          end
          RELEASE: begin
            if (idle) begin
              cnt_q <= cnt_inc;
              if (cnt_done) begin
                key_held <= 1'b0;
                state_q  <= SCAN;
                col_q    <= col_q + 2'd1;
                col_out  <= {col_out[2:0], col_out[3]};
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: physical keypad model, tick-level reference and strobe scoreboard.
module tb_keypad_scan;

  localparam int unsigned D = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_tick;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Physical key state, bit r*4+c set when key [r][c] is pressed.
  logic [15:0] pressed = '0;
  logic [15:0] last_mask = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  // Reference model state.
  int         m_col, m_run, m_row, m_rel;
  bit         m_held;
  logic [3:0] m_code;

  keypad_scan #(
    .DEBOUNCE_TICKS(D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_tick(scan_tick),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its row low when its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col_out[c] && pressed[r*4+c]) row_in[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] key_of(input int r, input int c);
    logic [63:0] lut;
    lut = 64'h123A_456B_789C_0FED;
    return lut[63 - 4*(r*4+c) -: 4];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A press is accepted after D consecutive ticks seeing the same single row
  // on a parked column; a release after D consecutive all-idle ticks.
  task automatic model_step();
    int nlow, idx;
    nlow = 0;
    idx  = 0;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r*4+m_col]) begin
        nlow++;
        idx = r;
      end
    end
    if (!m_held) begin
      if (m_run == 0) begin
        if (nlow == 1) begin
          m_row = idx;
          m_run = 1;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end else if (nlow == 1 && idx == m_row) begin
        m_run++;
        if (m_run == int'(D)) begin
          m_code = key_of(m_row, m_col);
          exp_q.push_back(m_code);
          m_held = 1'b1;
          m_run  = 0;
          m_rel  = 0;
        end
      end else begin
        m_run = 0;
        m_col = (m_col + 1) % 4;
      end
    end else begin
      if (nlow == 0) begin
        m_rel++;
        if (m_rel == int'(D)) begin
          m_held = 1'b0;
          m_rel  = 0;
          m_col  = (m_col + 1) % 4;
        end
      end else begin
        m_rel = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_col  = 0;
    m_run  = 0;
    m_row  = 0;
    m_rel  = 0;
    m_held = 1'b0;
    m_code = 4'h0;
  endtask

  // Back-to-back ticks only when rows cannot have changed recently.
  task automatic do_tick();
    int gap;
    logic [3:0] ec;
    gap = (pressed == '0 && last_mask == '0) ? $urandom_range(0, 3) : $urandom_range(3, 6);
    repeat (gap) @(negedge clk);
    scan_tick = 1'b1;
    @(posedge clk);
    model_step();
    last_mask = pressed;
    @(negedge clk);
    scan_tick = 1'b0;
    #1;
    ec = 4'hF;
    ec[m_col] = 1'b0;
    check("col_out", col_out, ec);
    check("key_held", key_held, m_held);
    check("key_code", key_code, m_code);
    check("strobe pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pressed   = '0;
    rst_n     = 1'b0;
    scan_tick = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst col_out", col_out, 4'b1110);
    check("rst key_valid", key_valid, 1'b0);
    check("rst key_held", key_held, 1'b0);
    check("rst key_code", key_code, 4'h0);
    rst_n     = 1'b1;
    scan_tick = 1'b0;
    model_reset();
    last_mask = '0;
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected key_valid: got code %0h, expected no strobe (t=%0t)",
                 key_code, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (key_code !== mon_exp) begin
          n_fail++;
          $display("FAIL strobe key_code: got %0h, expected %0h (t=%0t)",
                   key_code, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int kind, n, r, c;
    rst_n     = 1'b0;
    scan_tick = 1'b0;
    model_reset();
    do_reset();

    // Idle rotation.
    repeat (5) do_tick();

    // Press '5' (row 1, column 1) and hold.
    while (m_col != 1) do_tick();
    pressed = 16'h0001 << (1*4 + 1);
    repeat (3) do_tick();
    check("press 5 code", key_code, 4'h5);
    check("press 5 held", key_held, 1'b1);
    repeat (2) do_tick();

    // Release with a one-tick glitch.
    pressed = '0;
    repeat (2) do_tick();
    pressed = 16'h0001 << (1*4 + 1);
    do_tick();
    pressed = '0;
    repeat (2) do_tick();
    check("glitch still held", key_held, 1'b1);
    do_tick();
    check("glitch released", key_held, 1'b0);
    repeat (2) do_tick();

    // Bounce: one tick of contact then open.
    pressed = 16'h0001 << (2*4 + m_col);
    do_tick();
    pressed = '0;
    repeat (2) do_tick();

    // Two rows low on column 3 is ignored.
    while (m_col != 3) do_tick();
    pressed = (16'h0001 << (1*4 + 3)) | (16'h0001 << (2*4 + 3));
    repeat (4) do_tick();
    check("multi ignored", key_held, 1'b0);
    pressed = '0;
    repeat (2) do_tick();

    // Row 3 on column 3 is 'D'.
    while (m_col != 3) do_tick();
    pressed = 16'h0001 << (3*4 + 3);
    repeat (3) do_tick();
    check("press D code", key_code, 4'hD);
    pressed = '0;
    repeat (4) do_tick();

    // Reset in the middle of debounce.
    pressed = 16'h0001 << (0*4 + m_col);
    repeat (2) do_tick();
    do_reset();
    do_tick();

    // Randomized key activity.
    for (int s = 0; s < 250; s++) begin
      kind = $urandom_range(0, 99);
      n    = $urandom_range(1, 7);
      if (kind < 40) begin
        pressed = '0;
      end else if (kind < 85) begin
        r = $urandom_range(0, 3);
        c = ($urandom_range(0, 1) == 1) ? m_col : $urandom_range(0, 3);
        pressed = '0;
        pressed[r*4+c] = 1'b1;
      end else begin
        pressed = '0;
        pressed[$urandom_range(0, 15)] = 1'b1;
        pressed[$urandom_range(0, 15)] = 1'b1;
      end
      repeat (n) do_tick();
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    pressed = '0;
    repeat (D + 2) do_tick();
    check("final queue empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad one column at a time, paced by the one-cycle scan strobe from the upstream tick generator. Debounces both press and release, and emits a one-cycle `key_valid` strobe with a 4-bit hex key code per debounced press. It sits between the tick generator and the lock's code-entry FSM and seven-segment logic. It does not auto-repeat.

## Interface
- `DEBOUNCE_TICKS`, default 3: consecutive agreeing scan ticks required to accept a press or a release. Legal range is 2..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `scan_tick`  in  1  one-cycle strobe from the tick generator. Every `clk` cycle in which it is high counts as one tick.
- `row_in`  in  4  keypad rows, active-low with external pull-ups, asynchronous to `clk`.
- `col_out`  out  4  column drive, active-low. Exactly one bit is low at all times.
- `key_code`  out  4  hex value of the last accepted key. Holds until the next accepted press.
- `key_valid`  out  1  one-cycle strobe when `key_code` is updated.
- `key_held`  out  1  high from acceptance of a press until its release is debounced.

## Operation
- `row_in` passes through a 2-FF synchronizer; call the result `rows_s`. Synchronizer flops reset to 4'hF.
- `rows_s` is sampled only on cycles where `scan_tick=1`. Columns change only on those same edges, so each column is stable for a full tick period before it is sampled.
- "Single hit" means exactly one bit of `rows_s` is 0. "Idle" means `rows_s`=4'hF. Any pattern with two or more low bits counts as neither single hit nor idle.
- The FSM uses a counter `cnt` (4 bits) and a captured row index `row_q`. Each tick is handled per state:
  - **SCAN**:
    - Single hit: set `row_q` to that row, `cnt`=1, go to DEBOUNCE. The column is held.
    - Otherwise: advance the column (0→1→2→3→0).
  - **DEBOUNCE**:
    - Single hit on the same row: `cnt`+1. When `cnt` reaches `DEBOUNCE_TICKS`, latch `key_code`, pulse `key_valid`, set `key_held`=1, go to HELD.
    - Any other pattern: go to SCAN and advance the column.
  - **HELD**:
    - Idle: `cnt`=1, go to RELEASE.
    - Otherwise: stay. Extra keys pressed while held are ignored.
  - **RELEASE**:
    - Idle: `cnt`+1. When `cnt` reaches `DEBOUNCE_TICKS`, clear `key_held`, go to SCAN and advance the column.
    - Not idle: go back to HELD. There is no new `key_valid`.
- Key map, indexed [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D

## Timing
- Reset values: `col_out`=4'b1110 (column 0), `key_code`=4'h0, `key_valid`=0, `key_held`=0, state SCAN, `cnt`=0.
- Reset is sampled synchronously. `rst_n` low mid-debounce or mid-hold returns everything to the reset values on the next edge, with no `key_valid`. `scan_tick` is ignored while `rst_n`=0.
- `row_in` to `rows_s` takes 2 `clk` cycles. This is negligible against the tick period; the bench must hold `row_in` at least 3 `clk` cycles before a tick.
- `key_valid`, `key_code` and `key_held` are registered. They change on the edge that processes the accepting tick, so they are visible in the cycle after `scan_tick` is high.
- Press latency, measured from the first tick where the key's column is driven: `DEBOUNCE_TICKS` ticks to `key_valid`, i.e. `key_valid` follows tick number `DEBOUNCE_TICKS` counting that first tick as tick 1.
- Worst-case detection time is up to 3 extra ticks waiting for the column to come round.
- `key_valid` is never high for two consecutive cycles. There is at most one `key_valid` per press/release cycle.
- Back-to-back `scan_tick` cycles are legal, and each one counts.

## Structure
- Package `keypad_pkg` holds:
  - `NUM_ROWS`=4 and `NUM_COLS`=4
  - state enum `kp_state_t` {SCAN, DEBOUNCE, HELD, RELEASE}
  - `KEY_MAP` constant, 4x4 array of 4-bit values
  - function `one_hot_low_idx`, returning the index of the low row plus a valid flag
- Sub-module `sync_2ff`, parameterized by width and instantiated with width 4 for `row_in`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with ticks → `col_out`=1110, `key_valid`=0, `key_held`=0, `key_code`=0.
- Idle rotation: `row_in`=F with 5 ticks → `col_out` steps 1110, 1101, 1011, 0111, 1110. No `key_valid`.
- Press '5': drive `row_in`=1101 whenever `col_out`=1101, for 3 ticks → one `key_valid`, `key_code`=5, `key_held`=1. `col_out` stays at 1101 while the key is held.
- Bounce: row low for 1 tick then F → no `key_valid`, and `col_out` advances on the next tick.
- Release with glitch: while HELD, rows F for 2 ticks, low for 1 tick, then F for 3 ticks → `key_held` drops only after the final 3 idle ticks. There is no second `key_valid`, and scanning resumes.
- Edge cases:
  - Rows 1001 on column 3 → ignored.
  - `row_in`=0111 on column 3 → `key_code`=D.
  - Reset asserted during DEBOUNCE → no `key_valid`, reset values restored.
